// File: rtl/pipeline_pkg.sv
// Shared pipeline-boundary types: stage occupancy states, the decode/execute
// payload layout and its architectural NOP (addi x0, x0, 0).
package pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam logic [6:0]  NOP_OPCODE = 7'h13;
  localparam logic [4:0]  NOP_RD     = 5'd0;
  localparam logic [2:0]  NOP_FUNCT3 = 3'd0;
  localparam logic [4:0]  NOP_RS1    = 5'd0;
  localparam logic [4:0]  NOP_RS2    = 5'd0;
  localparam logic [6:0]  NOP_FUNCT7 = 7'd0;
  localparam logic [31:0] NOP_IMM    = 32'd0;
  localparam logic [31:0] NOP_DATA   = 32'd0;
  localparam logic [31:0] NOP_PC     = 32'd0;

  // Opcode sits in the LSBs so a packed NOP reads as 0x13 in the low byte.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] imm;
    logic [6:0]  funct7;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } dec_ex_payload_t;

  localparam int DEC_EX_W = $bits(dec_ex_payload_t);

  function automatic dec_ex_payload_t build_nop_payload();
    dec_ex_payload_t p;
    p.pc     = NOP_PC;
    p.data   = NOP_DATA;
    p.imm    = NOP_IMM;
    p.funct7 = NOP_FUNCT7;
    p.rs2    = NOP_RS2;
    p.rs1    = NOP_RS1;
    p.funct3 = NOP_FUNCT3;
    p.rd     = NOP_RD;
    p.opcode = NOP_OPCODE;
    return p;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// Load-enabled payload register that resets to the bubble payload; used for
// both the main and the skid entry of a pipeline stage.
module pipe_skid_slot
  import pipeline_pkg::*;
#(
  parameter int               WIDTH       = 128,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: payload storage is reset too, so a bubble never carries stale
  // fields even before the first beat is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline boundary register with optional two-entry skid buffer,
// synchronous flush and NOP masking of the payload during bubbles.
module pipe_stage_reg
  import pipeline_pkg::*;
#(
  parameter int               WIDTH       = 128,
  parameter bit               SKID_EN     = 1'b1,
  parameter logic [WIDTH-1:0] NOP_PAYLOAD = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload,
  output logic [1:0]       occupancy
);

  stage_state_e     state_q, state_d;
  logic             alive_q;
  logic             in_fire, out_fire;
  logic             main_load, main_from_skid;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  // alive_q holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  generate
    if (SKID_EN) begin : g_ready_reg
      assign in_ready = alive_q & (state_q != FULL);
    end else begin : g_ready_comb
      assign in_ready = alive_q & ((state_q == EMPTY) | out_ready);
    end
  endgenerate

  assign out_valid = (state_q != EMPTY) & ~flush;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // NOTE: every combinational output gets a default first so no latch is
  // inferred on paths that leave it unassigned.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d   = EMPTY;
      main_load = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire && SKID_EN) begin
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_d = flush          ? NOP_PAYLOAD :
                  main_from_skid ? skid_q      : in_payload;

  pipe_skid_slot #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (NOP_PAYLOAD)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic             skid_load;
      logic [WIDTH-1:0] skid_d;

      // The skid entry only captures a beat arriving while main is stalled.
      assign skid_load = flush | ((state_q == BUSY) & in_fire & ~out_fire);
      assign skid_d    = flush ? NOP_PAYLOAD : in_payload;

      pipe_skid_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (NOP_PAYLOAD)
      ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .d     (skid_d),
        .q     (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = NOP_PAYLOAD;
    end
  endgenerate

  assign out_payload = out_valid ? main_q : NOP_PAYLOAD;
  assign occupancy   = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: one skid-mode and one single-entry instance driven in
// lockstep and compared every cycle against a bounded-FIFO reference model.
module tb_pipe_stage_reg;

  localparam int             W    = 128;
  localparam logic [W-1:0]   NOP1 = '0;
  localparam logic [W-1:0]   NOP0 = 128'h13;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid [2];
  logic           in_ready [2];
  logic [W-1:0]   in_payload [2];
  logic           out_valid [2];
  logic           out_ready [2];
  logic [W-1:0]   out_payload [2];
  logic [1:0]     occupancy [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: index 1 = two-entry skid mode, index 0 = single entry.
  logic [W-1:0] mbuf [2][2];
  int           msize [2];
  bit           alive = 1'b0;
  bit           hold [2];

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .SKID_EN(1'b1), .NOP_PAYLOAD(NOP1)) dut_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_payload(in_payload[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_payload(out_payload[1]),
    .occupancy(occupancy[1])
  );

  pipe_stage_reg #(.WIDTH(W), .SKID_EN(1'b0), .NOP_PAYLOAD(NOP0)) dut_flat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_payload(in_payload[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_payload(out_payload[0]),
    .occupancy(occupancy[0])
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] nop_of(input int m);
    return (m == 1) ? NOP1 : NOP0;
  endfunction

  function automatic bit exp_in_ready(input int m);
    if (!alive) return 1'b0;
    return (m == 1) ? (msize[1] < 2) : (msize[0] == 0 || out_ready[0]);
  endfunction

  function automatic bit exp_out_valid(input int m);
    return (msize[m] > 0) && !flush;
  endfunction

  task automatic compare_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s/m%0d/in_ready", tag, m), W'(in_ready[m]), W'(exp_in_ready(m)));
      check($sformatf("%s/m%0d/out_valid", tag, m), W'(out_valid[m]), W'(exp_out_valid(m)));
      check($sformatf("%s/m%0d/out_payload", tag, m), out_payload[m],
            exp_out_valid(m) ? mbuf[m][0] : nop_of(m));
      check($sformatf("%s/m%0d/occupancy", tag, m), W'(occupancy[m]), W'(msize[m]));
    end
  endtask

  task automatic model_reset();
    alive = 1'b0;
    for (int m = 0; m < 2; m++) begin
      msize[m] = 0;
      hold[m]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit inf [2];
    bit outf [2];
    for (int m = 0; m < 2; m++) begin
      inf[m]  = in_valid[m] && exp_in_ready(m);
      outf[m] = exp_out_valid(m) && out_ready[m];
    end
    for (int m = 0; m < 2; m++) begin
      hold[m] = in_valid[m] && !inf[m] && !flush;
      if (flush) begin
        msize[m] = 0;
      end else begin
        if (outf[m]) begin
          mbuf[m][0] = mbuf[m][1];
          msize[m]--;
        end
        if (inf[m]) begin
          mbuf[m][msize[m]] = in_payload[m];
          msize[m]++;
        end
      end
    end
    alive = 1'b1;
  endtask

  // Inputs are driven at the falling edge; outputs settle and are checked
  // 1 time unit later, then the model advances on the rising edge.
  task automatic tick(input string tag);
    #1 compare_all(tag);
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input int m, input bit v, input logic [W-1:0] p, input bit ordy);
    in_valid[m]   = v;
    in_payload[m] = p;
    out_ready[m]  = ordy;
  endtask

  function automatic logic [W-1:0] rand_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    model_reset();
    for (int m = 0; m < 2; m++) drive(m, 1'b0, '0, 1'b0);

    // Reset, then idle
    #2 compare_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick("rel");
    check("idle_in_ready", W'(in_ready[1]), W'(1));
    check("idle_payload", out_payload[1], NOP1);
    check("idle_occ", W'(occupancy[1]), W'(0));

    // Continuous stream through the skid-mode stage
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1'b1, W'(i), 1'b1);
      check("stream_in_ready", W'(in_ready[1]), W'(1));
      tick("stream");
      check("stream_payload", out_payload[1], W'(i));
    end
    drive(1, 1'b0, '0, 1'b1);
    tick("drain");

    // Backpressure fills main then skid; delivery order preserved
    drive(1, 1'b1, W'('hA), 1'b0);
    tick("bp_a");
    check("bp_occ1", W'(occupancy[1]), W'(1));
    drive(1, 1'b1, W'('hB), 1'b0);
    tick("bp_b");
    check("bp_occ2", W'(occupancy[1]), W'(2));
    check("bp_in_ready", W'(in_ready[1]), W'(0));
    drive(1, 1'b1, W'('hC), 1'b0);
    tick("bp_c");
    check("bp_head", out_payload[1], W'('hA));
    drive(1, 1'b1, W'('hC), 1'b1);
    tick("bp_rel");
    check("bp_second", out_payload[1], W'('hB));
    tick("bp_swap");
    check("bp_third", out_payload[1], W'('hC));
    drive(1, 1'b0, '0, 1'b1);
    tick("bp_end");
    check("bp_empty", W'(out_valid[1]), W'(0));

    // Flush while FULL kills held and incoming beats
    drive(1, 1'b1, W'('hA), 1'b0);
    tick("fl_a");
    drive(1, 1'b1, W'('hB), 1'b0);
    tick("fl_b");
    drive(1, 1'b1, W'('hC), 1'b0);
    flush = 1'b1;
    tick("fl_kill");
    check("fl_occ", W'(occupancy[1]), W'(0));
    flush = 1'b0;
    drive(1, 1'b0, '0, 1'b1);
    #1 check("fl_payload", out_payload[1], NOP1);
    for (int i = 0; i < 3; i++) tick("fl_after");

    // Single-entry mode: in-place replacement on simultaneous fire
    drive(0, 1'b1, W'('h5), 1'b0);
    tick("ns_5");
    drive(0, 1'b0, '0, 1'b0);
    #1 check("ns_in_ready", W'(in_ready[0]), W'(0));
    tick("ns_stall");
    drive(0, 1'b1, W'('h6), 1'b1);
    tick("ns_swap");
    check("ns_payload", out_payload[0], W'('h6));
    check("ns_occ", W'(occupancy[0]), W'(1));
    drive(0, 1'b0, '0, 1'b1);
    tick("ns_drain");

    // Asynchronous reset mid-cycle while FULL
    drive(1, 1'b1, W'('h11), 1'b0);
    tick("ar_a");
    drive(1, 1'b1, W'('h22), 1'b0);
    tick("ar_b");
    drive(1, 1'b0, '0, 1'b1);
    #3 rst_n = 1'b0;
    model_reset();
    #1 compare_all("ar_low");
    check("ar_valid", W'(out_valid[1]), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick("ar_after");

    // Randomized traffic on both stages
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 2; m++) begin
        out_ready[m] = ($urandom_range(0, 3) != 0);
        if (!hold[m]) begin
          in_valid[m]   = ($urandom_range(0, 2) != 0);
          in_payload[m] = rand_payload();
        end
      end
      flush = ($urandom_range(0, 15) == 0);
      tick("rnd");
    end
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
